jtag_rx_read_arbiter: RTL and testbench

Read-side controller for the JTAG UART simulation read FIFO. It shares the single read port between two byte consumers (0 = CPU register path, 1 = stream/DMA path). It pops one byte at a time with a one-cycle `fifo_rd` pulse, captures `fifo_rdata`, and presents the byte to the granted consumer over a valid/ready handshake. It sits directly between the read FIFO's `fifo_rd`/`fifo_rdata`/`fifo_EF` pins and the two consumers.

---
 rtl/jtag_rx_read_arbiter.sv | 162 ++++++++++++++++
 tb/tb_jtag_rx_read_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_rx_read_arbiter.sv
// Read-side arbiter for the JTAG UART read FIFO: pops one byte per transaction and hands it to one of two consumers.
// Optional feature macro: JTAG_RX_ARB_TIMEOUT_EN (drop a presented byte after TIMEOUT cycles without ready).
module jtag_rx_read_arbiter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_EF,
    input  logic [7:0]       fifo_rdata,
    output logic             fifo_rd,
    input  logic [1:0]       req,
    input  logic [1:0]       ready,
    output logic [1:0]       valid,
    output logic [7:0]       data,
    output logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [7:0]       drop_cnt,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a byte is transferred in any cycle where valid[grant] and ready[grant] are both high;
    // valid never depends on ready, and once raised it holds with stable data until accepted (or dropped).

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPT    = 2'd2,
        S_PRESENT = 2'd3
    } state_e;

    if (TIMEOUT < 2) begin : g_timeout_range_check
        $error("jtag_rx_read_arbiter: TIMEOUT must be at least 2");
    end

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             grant_sel;
    logic             accept;

`ifdef JTAG_RX_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        drop_q, drop_d;
    logic              expire;
`endif

    // Round-robin only matters on a tie: the consumer not served last wins.
    always_comb begin
        grant_sel = grant_q;
        unique case (req)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_q;
            default: grant_sel = grant_q;
        endcase
    end

    assign accept = (state_q == S_PRESENT) && ready[grant_q];

`ifdef JTAG_RX_ARB_TIMEOUT_EN
    assign expire = (state_q == S_PRESENT) && !ready[grant_q] &&
                    (wait_q == WAIT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
`ifdef JTAG_RX_ARB_TIMEOUT_EN
        wait_d  = wait_q;
        drop_d  = drop_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_EF && (req != 2'b00)) begin
                    grant_d = grant_sel;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                data_d  = fifo_rdata;
                state_d = S_PRESENT;
`ifdef JTAG_RX_ARB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_PRESENT: begin
                if (accept) begin
                    if (grant_q) cnt1_d = cnt1_q + CNT_W'(1);
                    else         cnt0_d = cnt0_q + CNT_W'(1);
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
`ifdef JTAG_RX_ARB_TIMEOUT_EN
                else if (expire) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= 8'h00;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
`ifdef JTAG_RX_ARB_TIMEOUT_EN
            wait_q  <= '0;
            drop_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
`ifdef JTAG_RX_ARB_TIMEOUT_EN
            wait_q  <= wait_d;
            drop_q  <= drop_d;
`endif
        end
    end

    assign fifo_rd     = (state_q == S_READ);
    assign busy        = (state_q != S_IDLE);
    assign valid       = (state_q == S_PRESENT) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign data        = (state_q == S_PRESENT) ? data_q : 8'h00;
    assign grant       = grant_q;
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;
    assign dbg_state_o = state_q;

`ifdef JTAG_RX_ARB_TIMEOUT_EN
    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_jtag_rx_read_arbiter.sv
// Bench for jtag_rx_read_arbiter: FIFO model, delivered-byte scoreboard, vector table and corner-case sequences.
module tb_jtag_rx_read_arbiter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;
`ifdef JTAG_RX_ARB_TIMEOUT_EN
  localparam int BP_CYC  = 5;
`else
  localparam int BP_CYC  = 10;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             fifo_EF;
  logic [7:0]       fifo_rdata;
  logic             fifo_rd;
  logic [1:0]       req;
  logic [1:0]       ready;
  logic [1:0]       valid;
  logic [7:0]       data;
  logic             grant;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [7:0]       drop_cnt;
  logic [1:0]       dbg_state;

  jtag_rx_read_arbiter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_EF(fifo_EF), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .req(req), .ready(ready), .valid(valid), .data(data), .grant(grant), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1), .drop_cnt(drop_cnt), .dbg_state_o(dbg_state)
  );

  // scoreboard state
  logic [7:0] fq[$];
  logic [8:0] exp_q[$];
  int         rd_cyc[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rd_pulses = 0;
  int         accepted = 0;
  logic       rd_prev = 1'b0;
  logic       ef_d = 1'b1;

  typedef struct {
    logic [1:0] req;
    logic [1:0] rdy;
    logic [7:0] b;
    logic       g;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs on the falling edge, then advance the FIFO model after the rising edge.
  task automatic tick();
    logic [8:0] e;
    logic       rd_now;
    @(negedge clk);
    check("valid_not_both", 32'(valid == 2'b11), 32'd0);
    if (valid == 2'b00) check("data_zero_when_idle", 32'(data), 32'd0);
    if (fifo_rd) begin
      rd_pulses++;
      rd_cyc.push_back(cyc);
      check("rd_fifo_nonempty", 32'(fq.size() != 0), 32'd1);
      check("rd_not_back_to_back", 32'(rd_prev), 32'd0);
    end
    if ((valid & ready) != 2'b00) begin
      accepted++;
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", 32'({grant, data}), 32'h1ff);
      end else begin
        e = exp_q.pop_front();
        check("delivered_grant_data", 32'({grant, data}), 32'(e));
      end
    end
    rd_now = fifo_rd;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_now && fq.size() != 0) fifo_rdata = fq.pop_front();
    fifo_EF = ef_d;
    ef_d    = (fq.size() == 0);
    rd_prev = rd_now;
  endtask

  task automatic wait_accept(input int target, input string name);
    int n;
    n = 0;
    while (accepted < target && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(accepted), 32'(target));
  endtask

  task automatic wait_valid(input logic [1:0] v, input string name);
    int n;
    n = 0;
    while (valid != v && n < 30) begin
      tick();
      n++;
    end
    check(name, 32'(valid), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rp;
    int c1;
    int n;
    int base;

    vt[0] = '{req: 2'b01, rdy: 2'b11, b: 8'h77, g: 1'b0};
    vt[1] = '{req: 2'b10, rdy: 2'b10, b: 8'h5A, g: 1'b1};
    vt[2] = '{req: 2'b11, rdy: 2'b11, b: 8'hC1, g: 1'b0};
    vt[3] = '{req: 2'b11, rdy: 2'b11, b: 8'hD2, g: 1'b1};
    vt[4] = '{req: 2'b11, rdy: 2'b11, b: 8'hE3, g: 1'b0};
    vt[5] = '{req: 2'b11, rdy: 2'b11, b: 8'hF4, g: 1'b1};
    vt[6] = '{req: 2'b11, rdy: 2'b11, b: 8'h05, g: 1'b0};
    vt[7] = '{req: 2'b11, rdy: 2'b11, b: 8'h16, g: 1'b1};
    vt[8] = '{req: 2'b01, rdy: 2'b01, b: 8'h00, g: 1'b0};

    // reset
    rst_n = 1'b0; fifo_EF = 1'b1; fifo_rdata = 8'h00; req = 2'b00; ready = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // empty FIFO with both requests: nothing happens
    req = 2'b11;
    repeat (20) begin
      tick();
      check("empty_busy", 32'(busy), 32'd0);
    end
    check("empty_no_rd", 32'(rd_pulses), 32'd0);

    // single consumer, two bytes back to back
    req = 2'b00;
    fq.push_back(8'hA5); exp_q.push_back({1'b0, 8'hA5});
    fq.push_back(8'h3C); exp_q.push_back({1'b0, 8'h3C});
    req = 2'b01; ready = 2'b01;
    rd_cyc.delete();
    wait_accept(2, "single_accepts");
    check("single_rd_count", 32'(rd_cyc.size()), 32'd2);
    if (rd_cyc.size() == 2) check("single_rd_spacing", 32'(rd_cyc[1] - rd_cyc[0]), 32'd4);
    check("single_cnt0", 32'(cnt0), 32'd2);
    repeat (10) tick();
    check("single_no_more_rd", 32'(rd_pulses), 32'd2);
    check("single_idle", 32'(busy), 32'd0);

    // vector table: one byte per record, grant checked by the scoreboard
    for (int i = 0; i < 8; i++) begin
      base = accepted;
      req = vt[i].req; ready = vt[i].rdy;
      fq.push_back(vt[i].b);
      exp_q.push_back({vt[i].g, vt[i].b});
      wait_accept(base + 1, "vec_accept");
    end
    req = 2'b00; ready = 2'b00;
    check("table_cnt0", 32'(cnt0), 32'd6);
    check("table_cnt1", 32'(cnt1), 32'd4);
    check("table_drop", 32'(drop_cnt), 32'd0);

    // backpressure on consumer 1; req drops and the other ready toggles meanwhile
    rp = rd_pulses; c1 = int'(cnt1);
    req = 2'b10;
    fq.push_back(8'h9E); exp_q.push_back({1'b1, 8'h9E});
    wait_valid(2'b10, "bp_present");
    req = 2'b00; ready = 2'b01;
    for (int k = 1; k <= BP_CYC; k++) begin
      tick();
      check("bp_valid_hold", 32'(valid), 32'h2);
      check("bp_data_hold", 32'(data), 32'h9E);
    end
    ready = 2'b10;
    tick();
    ready = 2'b00;
    check("bp_cnt1", 32'(cnt1), 32'(c1 + 1));
    check("bp_single_rd", 32'(rd_pulses), 32'(rp + 1));
    check("bp_valid_off", 32'(valid), 32'd0);

`ifdef JTAG_RX_ARB_TIMEOUT_EN
    // timeout: byte dropped after TIMEOUT present cycles
    req = 2'b01; ready = 2'b00;
    fq.push_back(8'h61);
    wait_valid(2'b01, "to_present");
    n = 1;
    while (valid != 2'b00 && n < 50) begin
      tick();
      if (valid != 2'b00) n++;
    end
    check("to_present_cycles", 32'(n), 32'(TIMEOUT));
    check("to_drop_one", 32'(drop_cnt), 32'd1);

    // ready in the last allowed cycle wins over the drop
    fq.push_back(8'h62); exp_q.push_back({1'b0, 8'h62});
    wait_valid(2'b01, "to_last_present");
    repeat (TIMEOUT - 1) tick();
    ready = 2'b01;
    base = accepted;
    tick();
    ready = 2'b00;
    check("to_last_accept", 32'(accepted), 32'(base + 1));
    check("to_last_no_drop", 32'(drop_cnt), 32'd1);

    // saturation
    for (int k = 0; k < 299; k++) begin
      fq.push_back(8'(k));
      wait_valid(2'b01, "to_sat_present");
      n = 0;
      while (valid != 2'b00 && n < 20) begin
        tick();
        n++;
      end
    end
    check("to_drop_saturated", 32'(drop_cnt), 32'hFF);
`endif

    // reset in the middle of a transaction
    req = 2'b01; ready = 2'b00;
    fq.push_back(8'h4D);
    wait_valid(2'b01, "midrst_present");
    rp = rd_pulses;
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_cnt0", 32'(cnt0), 32'd0);
    check("midrst_cnt1", 32'(cnt1), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    rst_n = 1'b1; req = 2'b00;
    repeat (6) tick();
    check("midrst_no_rd", 32'(rd_pulses), 32'(rp));
    check("midrst_idle", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
